// File: rtl/acu_reservation_station_pkg.sv
// Shared types for the arithmetic reservation station: ALU opcodes, the ROB
// tag/ready/data bundle used on dispatch, broadcast and result buses, and the RS entry.
package acu_reservation_station_pkg;

    localparam int XLEN     = 32;
    localparam int RS_SIZE  = 8;
    localparam int ROB_SIZE = 8;
    localparam int TAG_W    = 4;

    typedef enum logic [3:0] {
        add, sub, sll, slt, sltu, xor_, srl, sra, or_, and_
    } acu_op_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rdy;
        logic [XLEN-1:0]  data;
    } sal_t;

    typedef struct packed {
        logic             valid;
        acu_op_t          op;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  v1;
        logic [TAG_W-1:0] q1;
        logic             r1;
        logic [XLEN-1:0]  v2;
        logic [TAG_W-1:0] q2;
        logic             r2;
    } acu_rs_entry_t;

endpackage

// File: rtl/acu_reservation_station_alu.sv
// Shared integer ALU for the reservation station; purely combinational, zero latency.
// No flow control: the result is valid whenever op/a/b are.
module acu_alu
    import acu_reservation_station_pkg::*;
#(
    parameter int width = XLEN
) (
    input  acu_op_t          op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] result
);

    localparam int SHAMT_W = $clog2(width);

    always_comb begin
        result = '0;
        unique case (op)
            add:     result = a + b;
            sub:     result = a - b;
            sll:     result = a << b[SHAMT_W-1:0];
            slt:     result = {{(width-1){1'b0}}, $signed(a) < $signed(b)};
            sltu:    result = {{(width-1){1'b0}}, a < b};
            xor_:    result = a ^ b;
            srl:     result = a >> b[SHAMT_W-1:0];
            sra:     result = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
            or_:     result = a | b;
            and_:    result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/acu_reservation_station.sv
// Arithmetic reservation station: holds ops until operands arrive, issues one per cycle, result 1 cycle after ready.
// Backpressure: stall_acu is raised while every entry is occupied; loads presented during stall are dropped.
module acu_reservation_station
    import acu_reservation_station_pkg::*;
#(
    parameter int width    = XLEN,
    parameter int size     = RS_SIZE,
    parameter int rob_size = ROB_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  acu_op_t          op,
    input  logic [TAG_W-1:0] tag,
    input  sal_t             src1,
    input  sal_t             src2,
    input  sal_t             rob_broadcast_bus [rob_size],
    output sal_t             acu_rs_o [size],
    output logic             stall_acu
);

    localparam int IDX_W = $clog2(size);
    localparam int CNT_W = $clog2(size + 1);

    acu_rs_entry_t    entries_q [size];
    acu_rs_entry_t    entries_d [size];
    sal_t             acu_rs_q  [size];
    sal_t             acu_rs_d  [size];
    acu_rs_entry_t    new_entry;
    sal_t             s1, s2;
    logic             free_vld, iss_vld;
    logic [IDX_W-1:0] free_idx, iss_idx;
    logic [CNT_W-1:0] valid_cnt;
    logic [width-1:0] alu_result;

    // A broadcast slot only counts when its own tag matches its index.
    function automatic sal_t bus_lookup(input logic [TAG_W-1:0] q);
        sal_t res;
        res = '0;
        for (int t = 0; t < rob_size; t++) begin
            if (q == TAG_W'(t) && rob_broadcast_bus[t].rdy && rob_broadcast_bus[t].tag == q)
                res = rob_broadcast_bus[t];
        end
        return res;
    endfunction

    function automatic sal_t resolve_src(input sal_t src);
        sal_t hit;
        hit = bus_lookup(src.tag);
        if (src.rdy)
            return src;
        if (hit.rdy)
            return '{tag: src.tag, rdy: 1'b1, data: hit.data};
        return src;
    endfunction

    always_comb begin
        s1 = resolve_src(src1);
        s2 = resolve_src(src2);
        new_entry = '{valid: 1'b1, op: op, tag: tag,
                      v1: s1.data, q1: s1.tag, r1: s1.rdy,
                      v2: s2.data, q2: s2.tag, r2: s2.rdy};
    end

    // Free-slot and issue priority encoders work off registered state only.
    always_comb begin
        free_vld  = 1'b0;
        free_idx  = '0;
        iss_vld   = 1'b0;
        iss_idx   = '0;
        valid_cnt = '0;
        for (int i = 0; i < size; i++) begin
            if (entries_q[i].valid) begin
                valid_cnt = valid_cnt + CNT_W'(1);
            end else if (!free_vld) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (entries_q[i].valid && entries_q[i].r1 && entries_q[i].r2 && !iss_vld) begin
                iss_vld = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end

    assign stall_acu = (valid_cnt == CNT_W'(size));

    acu_alu #(.width(width)) u_alu (
        .op     (entries_q[iss_idx].op),
        .a      (entries_q[iss_idx].v1),
        .b      (entries_q[iss_idx].v2),
        .result (alu_result)
    );

    always_comb begin
        entries_d = entries_q;
        acu_rs_d  = '{default: '0};
        for (int i = 0; i < size; i++) begin
            if (entries_q[i].valid) begin
                if (!entries_q[i].r1 && bus_lookup(entries_q[i].q1).rdy) begin
                    entries_d[i].v1 = bus_lookup(entries_q[i].q1).data;
                    entries_d[i].r1 = 1'b1;
                end
                if (!entries_q[i].r2 && bus_lookup(entries_q[i].q2).rdy) begin
                    entries_d[i].v2 = bus_lookup(entries_q[i].q2).data;
                    entries_d[i].r2 = 1'b1;
                end
            end
        end
        if (iss_vld) begin
            acu_rs_d[iss_idx]  = '{tag: entries_q[iss_idx].tag, rdy: 1'b1, data: alu_result};
            entries_d[iss_idx] = '0;
        end
        // The issuing slot is still valid in entries_q, so a load never lands on it.
        if (load && !stall_acu && free_vld)
            entries_d[free_idx] = new_entry;
        if (flush) begin
            entries_d = '{default: '0};
            acu_rs_d  = '{default: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '{default: '0};
            acu_rs_q  <= '{default: '0};
        end else begin
            entries_q <= entries_d;
            acu_rs_q  <= acu_rs_d;
        end
    end

    assign acu_rs_o = acu_rs_q;

endmodule
